// File: rtl/xor_fold_pkg.sv
// +----------------------------------------------------------------------------+
// | xor_fold_pkg : shared types and helpers for the serial XOR-fold engine     |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package xor_fold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int beats(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xor_lanes_mux.sv
// +----------------------------------------------------------------------------+
// | xor_lanes_mux : N-bit bitwise XOR built purely from 2:1 mux cells          |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module xor_lanes_mux #(
  parameter int N = 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_bit
      logic not_a;
      // Inverter realised as a mux selecting between constants.
      assign not_a = a[i] ? 1'b0 : 1'b1;
      assign y[i]  = b[i] ? not_a : a[i];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/xor_fold_serial.sv
// +----------------------------------------------------------------------------+
// | xor_fold_serial : bit-serial XOR-fold / parity engine, LANES bits per beat |
// | Option macro XOR_FOLD_ODD_PARITY_EN adds odd_mode (inverts parity bit).    |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module xor_fold_serial
  import xor_fold_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef XOR_FOLD_ODD_PARITY_EN
  input  logic             odd_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_fold,
  output logic             out_parity
);

  localparam int              BEATS     = beats(WIDTH, LANES);
  localparam int              CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if (((WIDTH % LANES) != 0) || (BEATS < 2)) begin : g_bad_cfg
      $fatal(1, "xor_fold_serial: WIDTH must be a multiple of LANES with at least 2 beats");
    end
  endgenerate

  state_t             state;
  state_t             state_n;
  logic [WIDTH-1:0]   shreg;
  logic [LANES-1:0]   acc;
  logic [LANES-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               step;
  logic               odd_q;
  logic [LANES:0]     par_chain;

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    step     = 1'b0;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == LAST_BEAT) state_n = DONE;
      end
      DONE: begin
        // Retiring the result frees the engine in the same cycle.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            state_n = BUSY;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      odd_q <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        shreg <= in_data;
        acc   <= '0;
        cnt   <= '0;
`ifdef XOR_FOLD_ODD_PARITY_EN
        odd_q <= odd_mode;
`endif
      end else if (step) begin
        shreg <= shreg >> LANES;
        acc   <= acc_next;
        cnt   <= (cnt == LAST_BEAT) ? cnt : cnt + 1'b1;
      end
    end
  end

  xor_lanes_mux #(.N(LANES)) u_acc_xor (
    .a (acc),
    .b (shreg[LANES-1:0]),
    .y (acc_next)
  );

  // Parity seed is the odd-mode flag so inversion costs no extra stage.
  assign par_chain[0] = odd_q;

  genvar p;
  generate
    for (p = 0; p < LANES; p++) begin : g_par
      xor_lanes_mux #(.N(1)) u_par_xor (
        .a (par_chain[p]),
        .b (acc[p]),
        .y (par_chain[p+1])
      );
    end
  endgenerate

  assign out_valid  = (state == DONE);
  assign out_fold   = out_valid ? acc : '0;
  assign out_parity = out_valid ? par_chain[LANES] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_xor_fold_serial.sv
// +----------------------------------------------------------------------------+
// | tb_xor_fold_serial : self-checking bench for xor_fold_serial (8b, 2 lanes)  |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_xor_fold_serial;

  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int LAT   = WIDTH / LANES;
`ifdef XOR_FOLD_ODD_PARITY_EN
  localparam bit ODD_EN = 1'b1;
`else
  localparam bit ODD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_fold;
  logic             out_parity;
  logic             odd_mode;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  xor_fold_serial #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef XOR_FOLD_ODD_PARITY_EN
    .odd_mode   (odd_mode),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_fold   (out_fold),
    .out_parity (out_parity)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && out_valid && out_ready) hs_cnt++;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [LANES-1:0] fold;
    logic             par;
  } vec_t;

  // Fold computed as XOR of every LANES-wide chunk of the word.
  function automatic logic [LANES-1:0] model_fold(input logic [WIDTH-1:0] d);
    logic [LANES-1:0] f;
    f = '0;
    for (int i = 0; i < LAT; i++) f = f ^ d[LANES*i +: LANES];
    return f;
  endfunction

  function automatic logic model_par(input logic [WIDTH-1:0] d, input logic odd);
    return (^model_fold(d)) ^ (ODD_EN & odd);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present a word from a negedge and return once it has been accepted (#1 after the edge).
  task automatic send(input logic [WIDTH-1:0] d, input logic odd);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    odd_mode = odd;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    odd_mode = ~odd;
  endtask

  // Count clock edges until out_valid is seen.
  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) chk("result_timeout", 0, 1);
  endtask

  vec_t vecs[5];
  int   lat;
  int   hs0;
  logic [WIDTH-1:0] d;
  logic             o;
  logic             seen;

  initial begin
    vecs[0] = '{8'hA5, 2'b00, 1'b0};
    vecs[1] = '{8'h07, 2'b10, 1'b1};
    vecs[2] = '{8'h01, 2'b01, 1'b1};
    vecs[3] = '{8'hFF, 2'b00, 1'b0};
    vecs[4] = '{8'h03, 2'b11, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    odd_mode  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_fold", out_fold, 0);
    chk("reset_out_parity", out_parity, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with latency checks
    foreach (vecs[i]) begin
      send(vecs[i].data, 1'b0);
      chk("busy_in_ready", in_ready, 0);
      wait_result(lat);
      chk("latency", lat, LAT);
      chk($sformatf("fold_%0h", vecs[i].data), out_fold, vecs[i].fold);
      chk($sformatf("parity_%0h", vecs[i].data), out_parity, vecs[i].par);
      @(posedge clk);
      #1;
      chk("retire_out_valid", out_valid, 0);
    end

    // Backpressure: held result, ignored input, single handshake
    out_ready = 1'b0;
    send(8'hFF, 1'b0);
    wait_result(lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h07;
    hs0 = hs_cnt;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_held", {out_valid, out_fold, out_parity, in_ready}, {1'b1, 2'b00, 1'b0, 1'b0});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_one_handshake", hs_cnt - hs0, 1);
    chk("bp_idle", {out_valid, in_ready}, 2'b01);

    // Back-to-back: in_valid held across the retire edge
    hs0 = hs_cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(posedge clk);
    #1;
    in_data = 8'h03;
    wait_result(lat);
    chk("b2b_lat1", lat, LAT);
    chk("b2b_res1", {out_fold, out_parity}, 3'b01_1);
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    chk("b2b_spacing", lat + 1, LAT + 1);
    chk("b2b_res2", {out_fold, out_parity}, 3'b11_0);
    @(posedge clk);
    #1;
    chk("b2b_handshakes", hs_cnt - hs0, 2);

    // Reset in the middle of a fold drops the word
    send(8'hA5, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    hs0 = hs_cnt;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("midreset_no_result", {seen, 31'(hs_cnt - hs0)}, 0);

`ifdef XOR_FOLD_ODD_PARITY_EN
    send(8'hA5, 1'b1);
    wait_result(lat);
    chk("odd_fold", out_fold, 2'b00);
    chk("odd_parity", out_parity, 1);
    @(posedge clk);
    #1;
`endif

    // Randomized words with random consumer stalls
    for (int r = 0; r < 40; r++) begin
      d = WIDTH'($urandom);
      o = 1'($urandom);
      out_ready = 1'b0;
      send(d, o);
      wait_result(lat);
      chk("rnd_latency", lat, LAT);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("rnd_fold_%0h", d), out_fold, model_fold(d));
      chk($sformatf("rnd_par_%0h", d), out_parity, model_par(d, o));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("rnd_retire", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
